// File: rtl/ball_motion_if.sv
// Control inputs and ball state outputs of the frame-locked motion controller.
// No valid/ready handshake: controls are levels sampled at frame ticks and the outputs are registered, stable between steps.
interface ball_motion_if;
  logic       ena;
  logic       vsync;
  logic [2:0] speed;
  logic       pause;
  logic       recentre;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic [1:0] bounce;
  logic       running;

  modport master (
    output ena, vsync, speed, pause, recentre,
    input  ball_x, ball_y, dir_x, dir_y, bounce, running
  );

  modport slave (
    input  ena, vsync, speed, pause, recentre,
    output ball_x, ball_y, dir_x, dir_y, bounce, running
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion controller: steps the ball centre once per
// FRAME_DIV frames on the leading edge of vsync, with wall bounce, pause and recentre.
module ball_motion_ctrl #(
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480,
  parameter int RADIUS           = 100,
  parameter int FRAME_DIV        = 1,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ball_motion_if.slave      bus,
  output logic [1:0]        dbg_state
);
  localparam logic [10:0] X_MIN    = 11'(RADIUS);
  localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - RADIUS);
  localparam logic [10:0] Y_MIN    = 11'(RADIUS);
  localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - RADIUS);
  localparam logic [9:0]  X_MID    = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_MID    = 10'(V_ACTIVE / 2);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic        VS_POL   = (VSYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vs_act, vs_q, tick;
  logic [7:0]  div_q, div_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [1:0]  bounce_q, bounce_d;
  logic [11:0] step_x, step_y;

  // Returns {new_pos, new_dir, hit}. The minus side compares before
  // subtracting so the position can never wrap below zero.
  function automatic logic [11:0] axis_step(
    input logic [9:0]  pos,
    input logic        dir,
    input logic [2:0]  spd,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    logic [10:0] p, s, n;
    p = {1'b0, pos};
    s = {8'd0, spd};
    n = p + s;
    if (dir) begin
      if (n >= hi) axis_step = {hi[9:0], 1'b0, 1'b1};
      else         axis_step = {n[9:0], 1'b1, 1'b0};
    end else begin
      if (p <= lo + s) begin
        axis_step = {lo[9:0], 1'b1, 1'b1};
      end else begin
        n = p - s;
        axis_step = {n[9:0], 1'b0, 1'b0};
      end
    end
  endfunction

  assign vs_act = bus.vsync ^ VS_POL;
  assign tick   = bus.ena & vs_act & ~vs_q;
  assign step_x = axis_step(x_q, dx_q, bus.speed, X_MIN, X_MAX);
  assign step_y = axis_step(y_q, dy_q, bus.speed, Y_MIN, Y_MAX);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bounce_d = 2'b00;
    if (bus.recentre) begin
      // Recentre wins over a coincident tick; that frame is simply lost.
      state_d = ST_ARM;
      div_d   = 8'd0;
      x_d     = X_MID;
      y_d     = Y_MID;
      dx_d    = 1'b1;
      dy_d    = 1'b1;
    end else if (tick) begin
      unique case (state_q)
        ST_ARM: state_d = ST_RUN;
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (div_q == DIV_LAST) begin
            div_d    = 8'd0;
            x_d      = step_x[11:2];
            dx_d     = step_x[1];
            y_d      = step_y[11:2];
            dy_d     = step_y[1];
            bounce_d = {step_x[0], step_y[0]};
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        ST_PAUSE: if (!bus.pause) state_d = ST_RUN;
        default:  state_d = ST_ARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARM;
      vs_q     <= 1'b0;
      div_q    <= 8'd0;
      x_q      <= X_MID;
      y_q      <= Y_MID;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      bounce_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      vs_q     <= vs_act;
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      bounce_q <= bounce_d;
    end
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.dir_x   = dx_q;
  assign bus.dir_y   = dy_q;
  assign bus.bounce  = bounce_q;
  assign bus.running = (state_q == ST_RUN);
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: two instances (FRAME_DIV 1 and 3) share stimulus and
// are checked every cycle against a frame-level model plus hand-computed literals.
module tb_ball_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, vsync, pause, recentre;
  logic [2:0] speed;
  logic [1:0] dbg0, dbg3;

  int n_cmp = 0;
  int n_bad = 0;
  int bx_cnt = 0;
  int both_cnt = 0;
  bit cmp_en = 1'b0;

  ball_motion_if bus0 ();
  ball_motion_if bus3 ();

  assign bus0.ena = ena;      assign bus3.ena = ena;
  assign bus0.vsync = vsync;  assign bus3.vsync = vsync;
  assign bus0.speed = speed;  assign bus3.speed = speed;
  assign bus0.pause = pause;  assign bus3.pause = pause;
  assign bus0.recentre = recentre;  assign bus3.recentre = recentre;

  ball_motion_ctrl #(.FRAME_DIV(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0));
  ball_motion_ctrl #(.FRAME_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(dbg3));

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int P_ARM = 0, P_RUN = 1, P_PAUSE = 2;
  int fdiv[2] = '{1, 3};
  int mx[2], my[2], mdx[2], mdy[2], mb[2], mphase[2], mframes[2];
  bit m_vs_prev;

  function automatic void move(inout int p, inout int d, input int s, input int lo,
                               input int hi, output int hit);
    hit = 0;
    if (d == 1) begin
      if (p + s >= hi) begin p = hi; d = 0; hit = 1; end
      else p = p + s;
    end else begin
      if (p <= lo + s) begin p = lo; d = 1; hit = 1; end
      else p = p - s;
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 320; my[k] = 240; mdx[k] = 1; mdy[k] = 1;
      mb[k] = 0; mphase[k] = P_ARM; mframes[k] = 0;
    end
    m_vs_prev = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit frame_edge;
      int hx, hy;
      frame_edge = ena && (vsync == 1'b0) && !m_vs_prev;
      m_vs_prev  = (vsync == 1'b0);
      for (int k = 0; k < 2; k++) begin
        mb[k] = 0;
        if (recentre) begin
          mx[k] = 320; my[k] = 240; mdx[k] = 1; mdy[k] = 1;
          mphase[k] = P_ARM; mframes[k] = 0;
        end else if (frame_edge) begin
          if (mphase[k] == P_ARM) begin
            mphase[k] = P_RUN;
          end else if (mphase[k] == P_PAUSE) begin
            if (!pause) mphase[k] = P_RUN;
          end else if (pause) begin
            mphase[k] = P_PAUSE;
          end else begin
            mframes[k]++;
            if (mframes[k] == fdiv[k]) begin
              mframes[k] = 0;
              move(mx[k], mdx[k], int'(speed), 100, 540, hx);
              move(my[k], mdy[k], int'(speed), 100, 380, hy);
              mb[k] = hx * 2 + hy;
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input int x, input int y, input int dx, input int dy,
                         input int b, input int r);
    chk($sformatf("dut%0d ball_x", k), x, mx[k]);
    chk($sformatf("dut%0d ball_y", k), y, my[k]);
    chk($sformatf("dut%0d dir_x", k), dx, mdx[k]);
    chk($sformatf("dut%0d dir_y", k), dy, mdy[k]);
    chk($sformatf("dut%0d bounce", k), b, mb[k]);
    chk($sformatf("dut%0d running", k), r, int'(mphase[k] == P_RUN));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut(0, int'(bus0.ball_x), int'(bus0.ball_y), int'(bus0.dir_x), int'(bus0.dir_y),
              int'(bus0.bounce), int'(bus0.running));
      cmp_dut(1, int'(bus3.ball_x), int'(bus3.ball_y), int'(bus3.dir_x), int'(bus3.dir_y),
              int'(bus3.bounce), int'(bus3.running));
      if (rst_n && bus0.bounce[1]) bx_cnt++;
      if (rst_n && bus0.bounce == 2'b11) both_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
      @(negedge clk) vsync = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_recentre();
    @(negedge clk) recentre = 1'b1;
    @(negedge clk) recentre = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; ena = 1'b1; vsync = 1'b1; pause = 1'b0; recentre = 1'b0; speed = 3'd1;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk("reset ball_x", int'(bus0.ball_x), 320);
    chk("reset ball_y", int'(bus0.ball_y), 240);
    chk("reset running", int'(bus0.running), 0);

    // speed 1 sweep: arm, y wall at tick 140, x wall at tick 220, shared corner at 1540
    frames(1);
    chk("armed no step x", int'(bus0.ball_x), 320);
    chk("armed running", int'(bus0.running), 1);
    frames(140);
    chk("y wall tick140", int'(bus0.ball_y), 380);
    chk("y dir tick140", int'(bus0.dir_y), 0);
    frames(80);
    chk("x wall tick220", int'(bus0.ball_x), 540);
    chk("x dir tick220", int'(bus0.dir_x), 0);
    chk("x bounce pulses", bx_cnt, 1);
    frames(1);
    chk("x tick221", int'(bus0.ball_x), 539);
    frames(1319);
    chk("corner x", int'(bus0.ball_x), 100);
    chk("corner y", int'(bus0.ball_y), 100);
    chk("corner bounce 11", both_cnt, 1);

    // clamp with speed 7
    do_recentre();
    speed = 3'd7;
    frames(1);
    frames(31);
    chk("speed7 tick31", int'(bus0.ball_x), 537);
    frames(1);
    chk("speed7 clamp", int'(bus0.ball_x), 540);
    frames(1);
    chk("speed7 rebound", int'(bus0.ball_x), 533);

    // divider on the FRAME_DIV=3 instance
    do_recentre();
    speed = 3'd2;
    frames(1);
    frames(2);
    chk("div3 hold", int'(bus3.ball_x), 320);
    frames(1);
    chk("div3 tick3", int'(bus3.ball_x), 322);
    frames(3);
    chk("div3 tick6", int'(bus3.ball_x), 324);
    chk("div1 tick6", int'(bus0.ball_x), 332);

    // pause for 10 ticks, resume tick does not step
    @(negedge clk) pause = 1'b1;
    frames(10);
    chk("paused x", int'(bus0.ball_x), 332);
    chk("paused running", int'(bus0.running), 0);
    @(negedge clk) pause = 1'b0;
    frames(1);
    chk("resume no step", int'(bus0.ball_x), 332);
    chk("resume running", int'(bus0.running), 1);
    frames(1);
    chk("resume step", int'(bus0.ball_x), 334);

    // recentre coincident with a tick at x=500
    frames(83);
    chk("reach 500", int'(bus0.ball_x), 500);
    @(negedge clk) begin recentre = 1'b1; vsync = 1'b0; end
    @(negedge clk) recentre = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    chk("recentre x", int'(bus0.ball_x), 320);
    chk("recentre y", int'(bus0.ball_y), 240);
    chk("recentre dir_x", int'(bus0.dir_x), 1);
    chk("recentre running", int'(bus0.running), 0);
    frames(1);
    chk("rearm no step", int'(bus0.ball_x), 320);
    frames(1);
    chk("rearm step", int'(bus0.ball_x), 322);

    // long sync pulse gives one tick
    @(negedge clk) vsync = 1'b0;
    repeat (5000) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("long vsync one step", int'(bus0.ball_x), 324);

    // edge while ena low is skipped, no late tick when ena returns
    @(negedge clk) begin ena = 1'b0; vsync = 1'b0; end
    @(negedge clk) ena = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    chk("ena skip", int'(bus0.ball_x), 324);
    frames(1);
    chk("ena resumed", int'(bus0.ball_x), 326);

    // async reset in the middle of a step cycle
    @(negedge clk) vsync = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst x", int'(bus0.ball_x), 320);
    chk("async rst y", int'(bus0.ball_y), 240);
    chk("async rst dir_y", int'(bus0.dir_y), 1);
    chk("async rst bounce", int'(bus0.bounce), 0);
    chk("async rst running", int'(bus0.running), 0);
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    frames(1);
    chk("post rst arm", int'(bus0.ball_x), 320);
    frames(1);
    chk("post rst step", int'(bus0.ball_x), 322);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-synchronous motion controller for the bouncing-ball VGA demo. It sits directly upstream of the ball renderer and owns the ball centre coordinates and travel directions. It watches the vsync output of the timing generator and advances the ball once per frame, or once per `FRAME_DIV` frames, during vertical blanking, so the renderer always sees a stable position for a whole visible frame. It replaces the free-running cycle-count divider with frame-locked stepping, plus speed, pause and recentre controls.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in lines.
- `RADIUS`, 100: ball radius; sets the wall bounds.
- `FRAME_DIV`, 1: frames per motion step, range 1..255.
- `VSYNC_ACTIVE_LOW`, 1: 1 means the vsync pulse is low-active; 0 means it is high-active.

Ports:
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: when low, frame ticks are ignored and all state holds.
- `vsync`  in  1: vsync from the timing generator, in the same clock domain.
- `speed`  in  3: pixels per step on each axis; 0 means stationary.
- `pause`  in  1: freeze request, sampled only at frame ticks.
- `recentre`  in  1: synchronous recentre request, level-sensitive.
- `ball_x`  out  10: ball centre x, registered.
- `ball_y`  out  10: ball centre y, registered.
- `dir_x`  out  1: 1 means +x, 0 means -x.
- `dir_y`  out  1: 1 means +y, 0 means -y.
- `bounce`  out  2: one-cycle pulse. Bit 1 flags a wall hit on x, bit 0 flags a wall hit on y.
- `running`  out  1: high while in the RUN state.

## Operation

- **Frame tick.** `vs_act = vsync ^ VSYNC_ACTIVE_LOW`. A one-flop history `vs_q` stores the previous value. `tick = ena & vs_act & ~vs_q`, i.e. the leading edge of the sync pulse. `vs_q` updates every cycle regardless of `ena`.
- **Bounds.**
  - `X_MIN = RADIUS`, `X_MAX = H_ACTIVE-RADIUS`. With defaults these are 100 and 540.
  - `Y_MIN = RADIUS`, `Y_MAX = V_ACTIVE-RADIUS`. With defaults these are 100 and 380.
- **States.**
  - ARM (reset state): waits for the first tick. That tick moves to RUN without stepping.
  - RUN: on each tick, `div_cnt` increments. When `div_cnt == FRAME_DIV-1` the controller takes one step and clears `div_cnt`.
  - PAUSE: no motion and `div_cnt` holds.
  - Transitions on a tick: RUN with `pause=1` goes to PAUSE and does not step on that tick. PAUSE with `pause=0` goes to RUN and does not step on that tick.
- **Step, per axis, computed in 11-bit arithmetic.**
  - Moving +: `n = pos + speed`. If `n >= MAX`, then `pos = MAX`, `dir = 0`, and the matching bounce bit fires. Otherwise `pos = n`.
  - Moving −: if `pos <= MIN + speed`, then `pos = MIN`, `dir = 1`, and the matching bounce bit fires. Otherwise `pos = pos - speed`. This ordering prevents underflow.
  - `speed` is sampled on the step cycle.
  - With `speed=0`, position does not change. A position already at a bound still flips its direction and fires bounce.
- **Corner case.** Both axes may bounce on the same step, giving `bounce = 2'b11`.
- **Recentre.** While `recentre=1`: `ball_x = H_ACTIVE/2`, `ball_y = V_ACTIVE/2`, both dirs = 1, `div_cnt = 0`, state = ARM. Recentre has priority over a tick in the same cycle; that tick is lost.
- **Reset values.** `ball_x=320`, `ball_y=240` (that is, `H_ACTIVE/2`, `V_ACTIVE/2`), `dir_x=1`, `dir_y=1`, `bounce=0`, `running=0`, state ARM, `div_cnt=0`, `vs_q=0`.
  - Because `vs_q` resets to 0, a `vs_act` level already present when reset releases is taken as a tick on the first clock after reset.

## Timing

- Latency:
  - Cycle N: `tick` is asserted combinationally.
  - Edge ending cycle N: `ball_x`, `ball_y`, `dir_*`, `bounce`, `running` and the state all register.
  - Cycle N+1: new values are visible.
- `bounce` is high for exactly cycle N+1 and 0 otherwise.
- All updates occur inside vertical blanking, so positions are constant across every visible line.
- `running` is registered and mirrors the state.
- An async reset mid-frame forces the reset values immediately. The next tick arms the block; it does not step.
- A sync pulse held for many cycles produces exactly one tick.
- With `ena=0` during an edge, that frame is skipped. `vs_q` still tracks `vs_act`, so no extra tick appears when `ena` returns high.

## Test plan

- Reset, then 1 arming tick, then 220 ticks with `speed=1`, `FRAME_DIV=1`.
  - `ball_x=540` and `dir_x` becomes 0 on tick 220.
  - `bounce[1]=1` for one cycle.
  - Tick 221 gives `ball_x=539`.
  - Separately, `ball_y` reaches 380 on tick 140 with `bounce[0]=1`.
- Clamp check with `speed=7` after arming, running on from the 31 ticks that give `ball_x=537`.
  - Tick 32 gives `ball_x=540`, not 544.
  - Tick 33 gives `ball_x=533`.
- Divider check with `FRAME_DIV=3`, `speed=2`, after arming.
  - Position is unchanged after ticks 1 and 2.
  - Tick 3 gives `ball_x=322`.
  - Tick 6 gives `ball_x=324`.
- Pause:
  - `pause=1` at a tick: no motion and `running=0` for 10 ticks.
  - `pause=0` at the next tick: no step on that tick; the following tick steps.
- Recentre mid-run at `ball_x=500`, coincident with a tick: outputs become 320/240 with dirs 1, then one arming tick occurs before motion resumes.
- Vsync held active for 5000 cycles: exactly one step.
- Async reset asserted mid-step: outputs return to reset values within the same cycle and `bounce` stays 0.
